// File: rtl/scaler_counter_bank_pkg.sv
// Shared constants for the scaler counter bank and its readout register map.
// Optional feature macro: SCALER_COUNTER_PRESCALE_EN (per-channel prescaler).
package scaler_counter_bank_pkg;

    localparam int DEF_NUM_SCALERS   = 16;
    localparam int DEF_WIDTH         = 16;
    localparam int DEF_ADDR_BITS     = 4;
    localparam int DEF_PRESCALE_BITS = 2;

    // Base of the holding-register window; the bus decoder and software header both key off this.
    localparam logic [31:0] SCALER_REG_MAP_BASE = 32'h0000_0100;

endpackage : scaler_counter_bank_pkg

// File: rtl/scaler_counter_bank_if.sv
// Addressed read port of the scaler counter bank: the readout logic is master, the bank is slave.
interface scaler_counter_bank_if #(
    parameter int WIDTH     = scaler_counter_bank_pkg::DEF_WIDTH,
    parameter int ADDR_BITS = scaler_counter_bank_pkg::DEF_ADDR_BITS
) ();

    logic                 rd_i;
    logic [ADDR_BITS-1:0] addr_i;
    logic [WIDTH-1:0]     data_o;
    logic                 sat_o;
    logic                 valid_o;

    modport master (output rd_i, output addr_i, input data_o, input sat_o, input valid_o);
    modport slave  (input rd_i, input addr_i, output data_o, output sat_o, output valid_o);

endinterface : scaler_counter_bank_if

// File: rtl/scaler_counter_bank_channel.sv
// One channel: saturating live counter, optional prescaler, and the holding register it snapshots into.
// Optional feature macro: SCALER_COUNTER_PRESCALE_EN.
module scaler_counter_channel
    import scaler_counter_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
`ifdef SCALER_COUNTER_PRESCALE_EN
    , parameter int PRESCALE_BITS = DEF_PRESCALE_BITS
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flag_i,
    input  logic             period_i,
    output logic [WIDTH-1:0] hold_o,
    output logic             hold_sat_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d, hold_q;
    logic             sat_q, sat_d, hold_sat_q;
    logic             inc;

`ifdef SCALER_COUNTER_PRESCALE_EN
    logic [PRESCALE_BITS-1:0] pre_q, pre_d;

    always_comb begin
        pre_d = pre_q + PRESCALE_BITS'(flag_i);
        inc   = flag_i && (pre_q == '1);
    end
`else
    always_comb inc = flag_i;
`endif

    // The period-cycle flag is folded in here, so the snapshot takes cnt_d rather than cnt_q.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) cnt_d = cnt_q + WIDTH'(1);
        sat_d = sat_q | (cnt_d == '1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            hold_q     <= '0;
            hold_sat_q <= 1'b0;
`ifdef SCALER_COUNTER_PRESCALE_EN
            pre_q      <= '0;
`endif
        end else if (period_i) begin
            hold_q     <= cnt_d;
            hold_sat_q <= sat_d;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
`ifdef SCALER_COUNTER_PRESCALE_EN
            pre_q      <= '0;
`endif
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
`ifdef SCALER_COUNTER_PRESCALE_EN
            pre_q <= pre_d;
`endif
        end
    end

    assign hold_o     = hold_q;
    assign hold_sat_o = hold_sat_q;

endmodule : scaler_counter_channel

// File: rtl/scaler_counter_bank.sv
// Bank of saturating scaler counters with atomic period snapshot and a registered addressed read port.
// Optional feature macro: SCALER_COUNTER_PRESCALE_EN (per-channel prescaler ahead of each counter).
module scaler_counter_bank
    import scaler_counter_bank_pkg::*;
#(
    parameter int NUM_SCALERS   = DEF_NUM_SCALERS,
    parameter int WIDTH         = DEF_WIDTH,
    parameter int ADDR_BITS     = DEF_ADDR_BITS,
    parameter int PRESCALE_BITS = DEF_PRESCALE_BITS
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_SCALERS-1:0] scaler_i,
    input  logic                   period_i,
    output logic                   update_o,
    scaler_counter_bank_if.slave   bus
);

    if ((1 << ADDR_BITS) < NUM_SCALERS) begin : g_bad_addr_bits
        $error("ADDR_BITS too narrow for NUM_SCALERS");
    end
    if (PRESCALE_BITS < 1) begin : g_bad_prescale_bits
        $error("PRESCALE_BITS must be at least 1");
    end

    logic [WIDTH-1:0]       hold_data [NUM_SCALERS];
    logic [NUM_SCALERS-1:0] hold_sat;

    for (genvar n = 0; n < NUM_SCALERS; n++) begin : g_chan
        scaler_counter_channel #(
            .WIDTH(WIDTH)
`ifdef SCALER_COUNTER_PRESCALE_EN
            , .PRESCALE_BITS(PRESCALE_BITS)
`endif
        ) u_chan (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .flag_i    (scaler_i[n]),
            .period_i  (period_i),
            .hold_o    (hold_data[n]),
            .hold_sat_o(hold_sat[n])
        );
    end

    logic             addr_ok;
    logic [WIDTH-1:0] rd_data_d, rd_data_q;
    logic             rd_sat_d, rd_sat_q;
    logic             valid_q, update_q;

    // Unmapped addresses read as zero but still complete the handshake.
    always_comb begin
        rd_data_d = '0;
        rd_sat_d  = 1'b0;
        addr_ok   = int'(bus.addr_i) < NUM_SCALERS;
        for (int n = 0; n < NUM_SCALERS; n++) begin
            if (addr_ok && (bus.addr_i == ADDR_BITS'(n))) begin
                rd_data_d = hold_data[n];
                rd_sat_d  = hold_sat[n];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
            rd_sat_q  <= 1'b0;
            valid_q   <= 1'b0;
            update_q  <= 1'b0;
        end else begin
            valid_q  <= bus.rd_i;
            update_q <= period_i;
            if (bus.rd_i) begin
                rd_data_q <= rd_data_d;
                rd_sat_q  <= rd_sat_d;
            end
        end
    end

    assign bus.data_o  = rd_data_q;
    assign bus.sat_o   = rd_sat_q;
    assign bus.valid_o = valid_q;
    assign update_o    = update_q;

endmodule : scaler_counter_bank

// File: tb/tb_scaler_counter_bank.sv
// Self-checking bench for scaler_counter_bank: vector table, corner sequences and random periods vs. a flag-count model.
// Honours SCALER_COUNTER_PRESCALE_EN when the build defines it.
`timescale 1ns/1ps
module tb_scaler_counter_bank;

    localparam int NS   = 8;
    localparam int W    = 4;
    localparam int AB   = 4;
`ifdef SCALER_COUNTER_PRESCALE_EN
    localparam int PB   = 2;
`else
    localparam int PB   = 0;
`endif
    localparam int MAXV = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] scaler;
    logic          period;
    logic          update;

    scaler_counter_bank_if #(.WIDTH(W), .ADDR_BITS(AB)) bus ();

    scaler_counter_bank #(
        .NUM_SCALERS  (NS),
        .WIDTH        (W),
        .ADDR_BITS    (AB),
        .PRESCALE_BITS(2)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .scaler_i(scaler),
        .period_i(period),
        .update_o(update),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Model: raw flag totals per channel; the counted value is derived arithmetically at snapshot time.
    int live_flags [NS];
    int snap_data  [NS];
    bit snap_sat   [NS];
    int exp_data;
    bit exp_sat;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int ch;
        int nflags;
        int exp_data;
        bit exp_sat;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic model_clear();
        for (int n = 0; n < NS; n++) begin
            live_flags[n] = 0;
            snap_data[n]  = 0;
            snap_sat[n]   = 1'b0;
        end
        exp_data = 0;
        exp_sat  = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, then compare every output after the edge.
    task automatic cycle(input logic [NS-1:0] flags, input bit per, input bit rd, input int addr);
        scaler     = flags;
        period     = per;
        bus.rd_i   = rd;
        bus.addr_i = AB'(addr);
        if (rd) begin
            exp_data = (addr < NS) ? snap_data[addr] : 0;
            exp_sat  = (addr < NS) ? snap_sat[addr]  : 1'b0;
        end
        for (int n = 0; n < NS; n++) live_flags[n] += int'(flags[n]);
        if (per) begin
            for (int n = 0; n < NS; n++) begin
                snap_data[n]  = ((live_flags[n] >> PB) > MAXV) ? MAXV : (live_flags[n] >> PB);
                snap_sat[n]   = (live_flags[n] >> PB) >= MAXV;
                live_flags[n] = 0;
            end
        end
        @(posedge clk);
        #1;
        scaler   = '0;
        period   = 1'b0;
        bus.rd_i = 1'b0;
        check("update_o", update, per);
        check($sformatf("valid_o addr=%0d", addr), bus.valid_o, rd);
        check($sformatf("data_o addr=%0d", addr), bus.data_o, exp_data);
        check($sformatf("sat_o addr=%0d", addr), bus.sat_o, exp_sat);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        check("reset data_o", bus.data_o, 0);
        check("reset sat_o", bus.sat_o, 0);
        check("reset valid_o", bus.valid_o, 0);
        check("reset update_o", update, 0);
    endtask

    task automatic flags_on(input int ch, input int k);
        for (int i = 0; i < k; i++) cycle(NS'(1) << ch, 1'b0, 1'b0, 0);
    endtask

    task automatic read(input int addr, output int d, output bit s);
        cycle('0, 1'b0, 1'b1, addr);
        d = int'(bus.data_o);
        s = bus.sat_o;
    endtask

    initial begin
        int d;
        bit s;
        int n_updates;

        rst        = 1'b1;
        scaler     = '0;
        period     = 1'b0;
        bus.rd_i   = 1'b0;
        bus.addr_i = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

`ifdef SCALER_COUNTER_PRESCALE_EN
        vecs[0] = '{3,  5,  1, 1'b0};
        vecs[1] = '{0,  1,  0, 1'b0};
        vecs[2] = '{1, 20,  5, 1'b0};
        vecs[3] = '{1,  2,  0, 1'b0};
        vecs[4] = '{5, 15,  3, 1'b0};
        vecs[5] = '{6, 14,  3, 1'b0};
        vecs[6] = '{6, 11,  2, 1'b0};
        vecs[7] = '{6,  1,  0, 1'b0};
        vecs[8] = '{4, 70, 15, 1'b1};
`else
        vecs[0] = '{3,  5,  5, 1'b0};
        vecs[1] = '{0,  1,  1, 1'b0};
        vecs[2] = '{1, 20, 15, 1'b1};
        vecs[3] = '{1,  2,  2, 1'b0};
        vecs[4] = '{5, 15, 15, 1'b1};
        vecs[5] = '{6, 14, 14, 1'b0};
        vecs[6] = '{6, 11, 11, 1'b0};
        vecs[7] = '{6,  1,  1, 1'b0};
        vecs[8] = '{4, 70, 15, 1'b1};
`endif

        // Idle periods: three update pulses, every channel reads zero.
        n_updates = 0;
        for (int i = 0; i < 3; i++) begin
            cycle('0, 1'b1, 1'b0, 0);
            n_updates += int'(update);
            cycle('0, 1'b0, 1'b0, 0);
        end
        check("idle update count", n_updates, 3);
        for (int a = 0; a < NS; a++) begin
            read(a, d, s);
            check($sformatf("idle ch%0d", a), d, 0);
        end

        // Vector table: flags on one channel, snapshot, read it and a neighbour.
        for (int i = 0; i < 9; i++) begin
            flags_on(vecs[i].ch, vecs[i].nflags);
            cycle('0, 1'b1, 1'b0, 0);
            read(vecs[i].ch, d, s);
            check($sformatf("vec%0d data", i), d, vecs[i].exp_data);
            check($sformatf("vec%0d sat", i), s, vecs[i].exp_sat);
            read((vecs[i].ch + 1) % NS, d, s);
            check($sformatf("vec%0d neighbour", i), d, 0);
            check($sformatf("valid drops vec%0d", i), bus.valid_o, 1'b1);
            cycle('0, 1'b0, 1'b0, 0);
            check($sformatf("data holds vec%0d", i), bus.data_o, 0);
        end

        // Flag coincident with period lands in the snapshot; the next one in the following period.
        cycle(NS'(1) << 7, 1'b1, 1'b0, 0);
        cycle(NS'(1) << 7, 1'b0, 1'b0, 0);
        read(7, d, s);
        check("boundary first", d, (PB == 0) ? 1 : 0);
        cycle('0, 1'b1, 1'b0, 0);
        read(7, d, s);
        check("boundary second", d, (PB == 0) ? 1 : 0);

        // Back-to-back periods, and a read issued in the snapshot cycle.
        flags_on(5, 3);
        cycle(NS'(1) << 4, 1'b1, 1'b0, 0);
        cycle(NS'(1) << 4, 1'b1, 1'b1, 5);
        check("read in snapshot cycle", bus.data_o, (PB == 0) ? 3 : 0);
        read(4, d, s);
        check("consecutive periods", d, (PB == 0) ? 1 : 0);

        // Reset mid-period discards the partial count.
        flags_on(2, 9);
        do_reset();
        read(2, d, s);
        check("post-reset hold", d, 0);
        flags_on(2, 4);
        cycle('0, 1'b1, 1'b0, 0);
        read(2, d, s);
        check("after mid reset", d, (PB == 0) ? 4 : 1);

        // Out-of-range addresses.
        read(15, d, s);
        check("addr15 data", d, 0);
        check("addr15 valid", bus.valid_o, 1'b1);
        read(8, d, s);
        check("addr8 data", d, 0);

        // Random periods with random reads against the model.
        for (int p = 0; p < 6; p++) begin
            int len;
            len = $urandom_range(5, 40);
            for (int c = 0; c < len; c++) begin
                cycle(NS'($urandom), (c == len - 1), bit'($urandom_range(0, 1)), $urandom_range(0, 15));
            end
            for (int a = 0; a < NS; a++) cycle(NS'($urandom), 1'b0, 1'b1, a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_scaler_counter_bank

// File: doc/scaler_counter_bank.md
# scaler_counter_bank

Accumulates the single-cycle scaler flags produced by the per-channel scaler generators into saturating counters over a fixed integration period, then snapshots all channels atomically into holding registers for register-bus readout. Sits directly downstream of the scaler generators, in their fast clock domain. Presents a simple addressed read port to the control/readout logic.

## Interface
Parameters:
- NUM_SCALERS, 16: number of scaler flag inputs/channels.
- WIDTH, 16: counter and holding-register width per channel.
- ADDR_BITS, 4: readout address width; must satisfy 2^ADDR_BITS >= NUM_SCALERS.
- PRESCALE_BITS, 2: prescale divider width, 2^PRESCALE_BITS flags per count. Used only with the prescale macro.

Ports:
- clk_i  in  1  clock, same domain as the scaler flags.
- rst_i  in  1  reset, synchronous, active-high.
- scaler_i  in  NUM_SCALERS  per-channel scaler flags, one-cycle pulses, bit n = channel n.
- period_i  in  1  one-cycle pulse marking the end of an integration period.
- rd_i  in  1  read strobe.
- addr_i  in  ADDR_BITS  channel to read.
- data_o  out  WIDTH  holding-register value of the addressed channel.
- sat_o  out  1  saturation flag of the addressed channel for the snapshotted period.
- valid_o  out  1  read data valid pulse.
- update_o  out  1  one-cycle pulse when a new snapshot has been taken.

## Operation
- Each channel has a live counter, a holding register, and a holding saturation bit.
- A flag increments the live counter by 1. At all-ones, the counter holds and sets a live saturation bit. No wrap.
- On period_i:
  - Every channel's live count, including a flag in the same cycle, is copied into its holding register.
  - The live saturation bit is copied too. A flag in this cycle that reaches all-ones sets the copied saturation bit.
  - Live counters and live saturation bits clear to 0 for the next cycle. No flag is lost or double-counted across the boundary.
- Snapshot is atomic. All channels latch on the same edge.
- Read: rd_i with addr_i = n captures holding register n and its saturation bit into data_o/sat_o.
  - A read in the snapshot cycle returns the old snapshot.
  - addr_i >= NUM_SCALERS returns data_o = 0, sat_o = 0, and valid_o still pulses.
- Back-to-back reads are allowed every cycle. No stall or backpressure.
- Reset clears live counters, holding registers, saturation bits, prescalers and all outputs.
- Reset asserted mid-period discards the partial count. No snapshot is produced for that period.

## Timing
- Reset values: data_o = 0, sat_o = 0, valid_o = 0, update_o = 0.
- Count latency: a flag in cycle t is reflected in the live counter at t+1.
- Snapshot: period_i high in cycle t gives new holding values and update_o = 1 at t+1. update_o is high for exactly one cycle.
- Read latency: rd_i in cycle t gives data_o/sat_o updated and valid_o = 1 at t+1. data_o holds until the next read.
- period_i on consecutive cycles: each edge snapshots. The second snapshot captures only the flags of the intervening cycle.

## Configuration
- Macro SCALER_COUNTER_PRESCALE_EN.
- Defined:
  - Each channel has a PRESCALE_BITS-bit prescaler ahead of the counter. The live counter increments on every 2^PRESCALE_BITS-th flag, when the prescaler wraps from all-ones to 0.
  - Prescalers clear on period_i and on reset. The residue is discarded.
  - Saturation is judged on the live counter.
- Undefined:
  - No prescaler logic. Every flag increments the counter and PRESCALE_BITS is ignored.

## Structure
- Shared package/include: default NUM_SCALERS, WIDTH, ADDR_BITS and PRESCALE_BITS constants. The readout register map base is also there, so that the bus decoder and software header agree.
- One sub-module, scaler_counter_channel, holds the live counter, the optional prescaler, the saturation logic and the holding register. It is instantiated NUM_SCALERS times in a generate loop.
- The top level holds the read mux, the valid/update pulse registers and the address range check.

## Test plan
- Reset then idle: 3 period_i pulses with no flags -> update_o pulses 3 times; every channel reads data_o = 0, sat_o = 0.
- Channel 3 gets 5 flags, channel 0 gets 1 flag, then period_i -> read addr 3 returns 5 and addr 0 returns 1, both with valid_o one cycle after rd_i. Other channels return 0.
- Boundary: a channel 7 flag in the same cycle as period_i, and one the cycle after -> snapshot includes the first flag. The next period reads 1.
- Saturation with WIDTH = 4: 20 flags on channel 1 -> reads 15 with sat_o = 1. The next period with 2 flags reads 2 with sat_o = 0.
- Reset mid-period after 9 flags, then 4 flags, then period_i -> reads 4. Addr 15 with NUM_SCALERS = 8 reads 0 with valid_o = 1.
- With SCALER_COUNTER_PRESCALE_EN and PRESCALE_BITS = 2: 11 flags then period_i -> reads 2. The next period with 1 flag reads 0.
